// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two CPU-side request ports and the single physical memory port
// of the memory arbiter.
//
// CPU instruction port : instr_read, instr_mem_address -> instr_mem_rdata, instr_mem_resp
// CPU data port        : data_read, data_write, data_mem_address, data_mem_wdata,
//                        data_mbe -> data_mem_rdata, data_mem_resp
// Physical memory port : pmem_read, pmem_write, pmem_address, pmem_wdata,
//                        pmem_mbe -> pmem_rdata, pmem_resp
//
// Modports:
//   slave  - the arbiter (takes CPU requests and memory responses)
//   master - the environment (CPU pipeline plus physical memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    // instruction fetch port
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;

    // data port
    logic        data_read;
    logic        data_write;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;

    // physical memory port
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  instr_read, instr_mem_address,
        output instr_mem_rdata, instr_mem_resp,
        input  data_read, data_write, data_mem_address, data_mem_wdata, data_mbe,
        output data_mem_rdata, data_mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output instr_read, instr_mem_address,
        input  instr_mem_rdata, instr_mem_resp,
        output data_read, data_write, data_mem_address, data_mem_wdata, data_mbe,
        input  data_mem_rdata, data_mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port physical memory between a CPU instruction fetch port
// and a CPU data port. Both requests are sampled together in IDLE, the data
// access is served first, then the fetch, and finally both completions are
// reported to the stalled pipeline in one common RELEASE cycle.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous reset, active low
//   bus  - mem_arbiter_if.slave (CPU instruction/data ports, pmem port)
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        INSTR   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic        i_pend_q, i_pend_d;
    logic        d_pend_q, d_pend_d;
    logic        wr_q,     wr_d;
    logic [29:0] i_addr_q, i_addr_d;    // word addresses; byte offset dropped
    logic [29:0] d_addr_q, d_addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  mbe_q,    mbe_d;
    logic [31:0] i_buf_q,  i_buf_d;
    logic [31:0] d_buf_q,  d_buf_d;

    // Byte-offset bits of the CPU addresses never reach the word-aligned pmem port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.instr_mem_address[1:0], bus.data_mem_address[1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            i_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
            wr_q     <= 1'b0;
            i_addr_q <= '0;
            d_addr_q <= '0;
            wdata_q  <= '0;
            mbe_q    <= '0;
            i_buf_q  <= '0;
            d_buf_q  <= '0;
        end else begin
            state_q  <= state_d;
            i_pend_q <= i_pend_d;
            d_pend_q <= d_pend_d;
            wr_q     <= wr_d;
            i_addr_q <= i_addr_d;
            d_addr_q <= d_addr_d;
            wdata_q  <= wdata_d;
            mbe_q    <= mbe_d;
            i_buf_q  <= i_buf_d;
            d_buf_q  <= d_buf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        i_pend_d = i_pend_q;
        d_pend_d = d_pend_q;
        wr_d     = wr_q;
        i_addr_d = i_addr_q;
        d_addr_d = d_addr_q;
        wdata_d  = wdata_q;
        mbe_d    = mbe_q;
        i_buf_d  = i_buf_q;
        d_buf_d  = d_buf_q;

        unique case (state_q)
            IDLE: begin
                // Everything the access needs is captured here, so CPU inputs
                // may change freely once the FSM has left IDLE.
                i_pend_d = bus.instr_read;
                d_pend_d = bus.data_read | bus.data_write;
                wr_d     = bus.data_write;      // write wins over a simultaneous read
                i_addr_d = bus.instr_mem_address[31:2];
                d_addr_d = bus.data_mem_address[31:2];
                wdata_d  = bus.data_mem_wdata;
                mbe_d    = bus.data_mbe;
                if (bus.data_read | bus.data_write) begin
                    state_d = DATA;
                end else if (bus.instr_read) begin
                    state_d = INSTR;
                end
            end

            DATA: begin
                if (bus.pmem_resp) begin
                    if (!wr_q) begin
                        d_buf_d = bus.pmem_rdata;
                    end
                    state_d = i_pend_q ? INSTR : RELEASE;
                end
            end

            INSTR: begin
                if (bus.pmem_resp) begin
                    i_buf_d = bus.pmem_rdata;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so the pmem command stays
    // stable for the whole access and is quiet in IDLE and RELEASE.
    // -------------------------------------------------------------------------
    logic in_data;
    logic in_instr;
    logic in_release;

    assign in_data    = (state_q == DATA);
    assign in_instr   = (state_q == INSTR);
    assign in_release = (state_q == RELEASE);

    assign bus.pmem_read    = (in_data & ~wr_q) | in_instr;
    assign bus.pmem_write   = in_data & wr_q;
    assign bus.pmem_address = in_data  ? {d_addr_q, 2'b00} :
                              in_instr ? {i_addr_q, 2'b00} : 32'h0;
    assign bus.pmem_wdata   = (in_data & wr_q) ? wdata_q : 32'h0;
    assign bus.pmem_mbe     = (in_data & wr_q) ? mbe_q   : 4'h0;

    // Both completions share the single RELEASE cycle.
    assign bus.instr_mem_resp  = in_release & i_pend_q;
    assign bus.data_mem_resp   = in_release & d_pend_q;
    assign bus.instr_mem_rdata = i_buf_q;
    assign bus.data_mem_rdata  = d_buf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural memory answers pmem
// commands after a programmable number of cycles and logs every command it
// sees; a monitor logs every CPU response. Each scenario task pushes the
// commands and responses it expects, drives the CPU requests, then pops and
// compares both logs.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
    } cmd_t;

    typedef struct {
        logic        i;
        logic        d;
        logic [31:0] irdata;
        logic [31:0] drdata;
        int          cyc;
    } resp_t;

    cmd_t  exp_cmd_q[$];
    cmd_t  obs_cmd_q[$];
    resp_t exp_resp_q[$];
    resp_t obs_resp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int mem_delay = 1;      // command cycles until pmem_resp (1 = first cycle)
    bit resp_en   = 1'b1;
    bit spurious  = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_ibuf = 32'h0;
    logic [31:0] exp_dbuf = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // Behavioural physical memory
    // -------------------------------------------------------------------------
    initial begin : responder
        int   cnt;
        cmd_t cur;
        cnt = 0;
        cur = '{1'b0, 32'h0, 32'h0, 4'h0};
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = 32'h0;
            if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
                cnt++;
                n_vec++;
                if (bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1) begin
                    n_err++;
                    $display("FAIL pmem_exclusive: read=%b write=%b, required not both high",
                             bus.pmem_read, bus.pmem_write);
                end
                if (cnt == 1) begin
                    cur.wr    = bus.pmem_write;
                    cur.addr  = bus.pmem_address;
                    cur.wdata = bus.pmem_wdata;
                    cur.mbe   = bus.pmem_mbe;
                    obs_cmd_q.push_back(cur);
                end else begin
                    n_vec++;
                    if (bus.pmem_write !== cur.wr || bus.pmem_address !== cur.addr ||
                        (cur.wr && (bus.pmem_wdata !== cur.wdata || bus.pmem_mbe !== cur.mbe))) begin
                        n_err++;
                        $display("FAIL pmem_stable: got wr=%b addr=%h wdata=%h mbe=%b, required wr=%b addr=%h wdata=%h mbe=%b",
                                 bus.pmem_write, bus.pmem_address, bus.pmem_wdata, bus.pmem_mbe,
                                 cur.wr, cur.addr, cur.wdata, cur.mbe);
                    end
                end
                if (resp_en && cnt >= mem_delay) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = bus.pmem_read ? mem_word(bus.pmem_address) : 32'hBAD0BAD0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (spurious) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = 32'hDEADBEEF;
                    spurious = 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // CPU response monitor
    // -------------------------------------------------------------------------
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.instr_mem_resp !== 1'b0 || bus.data_mem_resp !== 1'b0) begin
                r.i      = bus.instr_mem_resp;
                r.d      = bus.data_mem_resp;
                r.irdata = bus.instr_mem_rdata;
                r.drdata = bus.data_mem_rdata;
                r.cyc    = cyc;
                obs_resp_q.push_back(r);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // -------------------------------------------------------------------------
    task automatic idle_inputs();
        bus.instr_read        = 1'b0;
        bus.instr_mem_address = 32'h0;
        bus.data_read         = 1'b0;
        bus.data_write        = 1'b0;
        bus.data_mem_address  = 32'h0;
        bus.data_mem_wdata    = 32'h0;
        bus.data_mbe          = 4'h0;
    endtask

    task automatic wait_resp(input int need, input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            #1;
            if (obs_resp_q.size() >= need) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mbe);
        cmd_t c;
        c = '{wr, addr, wdata, mbe};
        exp_cmd_q.push_back(c);
    endtask

    task automatic push_resp(input logic i, input logic d, input int at_cyc);
        resp_t r;
        r = '{i, d, exp_ibuf, exp_dbuf, at_cyc};
        exp_resp_q.push_back(r);
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_cmd: read/write=%b, required 00", {bus.pmem_read, bus.pmem_write});
        end
        n_vec++;
        if (bus.pmem_address !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h, required 00000000", bus.pmem_address);
        end
        n_vec++;
        if (bus.pmem_wdata !== 32'h0 || bus.pmem_mbe !== 4'h0) begin
            n_err++;
            $display("FAIL reset_wbus: wdata=%h mbe=%b, required 0", bus.pmem_wdata, bus.pmem_mbe);
        end
        n_vec++;
        if ({bus.instr_mem_resp, bus.data_mem_resp} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_resp: got %b, required 00", {bus.instr_mem_resp, bus.data_mem_resp});
        end
        n_vec++;
        if (bus.instr_mem_rdata !== 32'h0 || bus.data_mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: instr=%h data=%h, required 0", bus.instr_mem_rdata, bus.data_mem_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        $display("reset: checked outputs in reset");
    endtask

    task automatic test_fetch_only();
        bit   ok;
        int   start;
        cmd_t e, o;
        resp_t re, ro;
        mem[32'h60] = 32'h00000013;
        mem_delay = 2;
        start = cyc;
        push_cmd(1'b0, 32'h60, 32'h0, 4'h0);
        exp_ibuf = 32'h00000013;
        push_resp(1'b1, 1'b0, start + 1 + mem_delay);
        bus.instr_read        = 1'b1;
        bus.instr_mem_address = 32'h60;
        @(posedge clk);
        #1;
        bus.instr_mem_address = 32'h1234;   // must be ignored outside IDLE
        wait_resp(1, 40, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL fetch_timeout: no instr_mem_resp within 40 cycles");
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            n_vec++;
            if (obs_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL fetch_cmd: no command, required wr=%b addr=%h", e.wr, e.addr);
            end else begin
                o = obs_cmd_q.pop_front();
                if (o.wr !== e.wr || o.addr !== e.addr) begin
                    n_err++;
                    $display("FAIL fetch_cmd: got wr=%b addr=%h, required wr=%b addr=%h", o.wr, o.addr, e.wr, e.addr);
                end
            end
        end
        n_vec++;
        if (obs_cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL fetch_extra_cmd: %0d extra commands, required 0", obs_cmd_q.size());
        end
        obs_cmd_q.delete();
        while (exp_resp_q.size() > 0) begin
            re = exp_resp_q.pop_front();
            n_vec++;
            if (obs_resp_q.size() == 0) begin
                n_err++;
                $display("FAIL fetch_resp: no response, required i=%b d=%b", re.i, re.d);
            end else begin
                ro = obs_resp_q.pop_front();
                if (ro.i !== re.i || ro.d !== re.d || ro.irdata !== re.irdata ||
                    ro.drdata !== re.drdata || ro.cyc != re.cyc) begin
                    n_err++;
                    $display("FAIL fetch_resp: got i=%b d=%b ird=%h drd=%h cyc=%0d, required i=%b d=%b ird=%h drd=%h cyc=%0d",
                             ro.i, ro.d, ro.irdata, ro.drdata, ro.cyc, re.i, re.d, re.irdata, re.drdata, re.cyc);
                end
            end
        end
        n_vec++;
        if (obs_resp_q.size() != 0) begin
            n_err++;
            $display("FAIL fetch_extra_resp: %0d extra responses, required 0", obs_resp_q.size());
        end
        obs_resp_q.delete();
        $display("fetch_only: addr 00000060 -> %h", exp_ibuf);
    endtask

    task automatic test_fetch_and_load();
        bit   ok;
        int   start;
        cmd_t e, o;
        resp_t re, ro;
        mem_delay = 1;
        start = cyc;
        push_cmd(1'b0, 32'h1000, 32'h0, 4'h0);
        push_cmd(1'b0, 32'h64, 32'h0, 4'h0);
        exp_dbuf = mem_word(32'h1000);
        exp_ibuf = mem_word(32'h64);
        push_resp(1'b1, 1'b1, start + 1 + 2 * mem_delay);
        bus.instr_read        = 1'b1;
        bus.instr_mem_address = 32'h64;
        bus.data_read         = 1'b1;
        bus.data_mem_address  = 32'h1002;
        wait_resp(1, 40, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL both_timeout: no response within 40 cycles");
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            n_vec++;
            if (obs_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL both_cmd: no command, required wr=%b addr=%h", e.wr, e.addr);
            end else begin
                o = obs_cmd_q.pop_front();
                if (o.wr !== e.wr || o.addr !== e.addr) begin
                    n_err++;
                    $display("FAIL both_cmd: got wr=%b addr=%h, required wr=%b addr=%h", o.wr, o.addr, e.wr, e.addr);
                end
            end
        end
        n_vec++;
        if (obs_cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL both_extra_cmd: %0d extra commands, required 0", obs_cmd_q.size());
        end
        obs_cmd_q.delete();
        while (exp_resp_q.size() > 0) begin
            re = exp_resp_q.pop_front();
            n_vec++;
            if (obs_resp_q.size() == 0) begin
                n_err++;
                $display("FAIL both_resp: no response, required i=%b d=%b", re.i, re.d);
            end else begin
                ro = obs_resp_q.pop_front();
                if (ro.i !== re.i || ro.d !== re.d || ro.irdata !== re.irdata ||
                    ro.drdata !== re.drdata || ro.cyc != re.cyc) begin
                    n_err++;
                    $display("FAIL both_resp: got i=%b d=%b ird=%h drd=%h cyc=%0d, required i=%b d=%b ird=%h drd=%h cyc=%0d",
                             ro.i, ro.d, ro.irdata, ro.drdata, ro.cyc, re.i, re.d, re.irdata, re.drdata, re.cyc);
                end
            end
        end
        n_vec++;
        if (obs_resp_q.size() != 0) begin
            n_err++;
            $display("FAIL both_extra_resp: %0d extra responses, required 0", obs_resp_q.size());
        end
        obs_resp_q.delete();
        $display("fetch_and_load: data 00001000 -> %h, instr 00000064 -> %h", exp_dbuf, exp_ibuf);
    endtask

    task automatic test_store();
        bit   ok;
        int   start;
        cmd_t e, o;
        resp_t re, ro;
        mem_delay = 3;
        start = cyc;
        push_cmd(1'b1, 32'h2000, 32'hAB000000, 4'b1000);
        push_resp(1'b0, 1'b1, start + 1 + mem_delay);   // buffers unchanged
        bus.data_read        = 1'b1;    // write must win over the read
        bus.data_write       = 1'b1;
        bus.data_mem_address = 32'h2003;
        bus.data_mem_wdata   = 32'hAB000000;
        bus.data_mbe         = 4'b1000;
        wait_resp(1, 40, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL store_timeout: no data_mem_resp within 40 cycles");
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            n_vec++;
            if (obs_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL store_cmd: no command, required wr=%b addr=%h", e.wr, e.addr);
            end else begin
                o = obs_cmd_q.pop_front();
                if (o.wr !== e.wr || o.addr !== e.addr || o.wdata !== e.wdata || o.mbe !== e.mbe) begin
                    n_err++;
                    $display("FAIL store_cmd: got wr=%b addr=%h wdata=%h mbe=%b, required wr=%b addr=%h wdata=%h mbe=%b",
                             o.wr, o.addr, o.wdata, o.mbe, e.wr, e.addr, e.wdata, e.mbe);
                end
            end
        end
        n_vec++;
        if (obs_cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL store_extra_cmd: %0d extra commands, required 0", obs_cmd_q.size());
        end
        obs_cmd_q.delete();
        while (exp_resp_q.size() > 0) begin
            re = exp_resp_q.pop_front();
            n_vec++;
            if (obs_resp_q.size() == 0) begin
                n_err++;
                $display("FAIL store_resp: no response, required i=%b d=%b", re.i, re.d);
            end else begin
                ro = obs_resp_q.pop_front();
                if (ro.i !== re.i || ro.d !== re.d || ro.irdata !== re.irdata ||
                    ro.drdata !== re.drdata || ro.cyc != re.cyc) begin
                    n_err++;
                    $display("FAIL store_resp: got i=%b d=%b ird=%h drd=%h cyc=%0d, required i=%b d=%b ird=%h drd=%h cyc=%0d",
                             ro.i, ro.d, ro.irdata, ro.drdata, ro.cyc, re.i, re.d, re.irdata, re.drdata, re.cyc);
                end
            end
        end
        n_vec++;
        if (obs_resp_q.size() != 0) begin
            n_err++;
            $display("FAIL store_extra_resp: %0d extra responses, required 0", obs_resp_q.size());
        end
        obs_resp_q.delete();
        $display("store: addr 00002003 wdata ab000000 mbe 1000");
    endtask

    task automatic test_back_to_back();
        bit   ok;
        int   start;
        cmd_t e, o;
        resp_t re, ro;
        mem_delay = 1;
        start = cyc;
        push_cmd(1'b0, 32'h0, 32'h0, 4'h0);
        push_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        exp_ibuf = mem_word(32'h0);
        push_resp(1'b1, 1'b0, start + 2);
        bus.instr_read        = 1'b1;
        bus.instr_mem_address = 32'h0;
        wait_resp(1, 40, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_timeout1: no first instr_mem_resp within 40 cycles");
        end
        @(posedge clk);
        #1;
        bus.instr_mem_address = 32'h4;      // read stays high: new request
        start = cyc;
        exp_ibuf = mem_word(32'h4);
        push_resp(1'b1, 1'b0, start + 2);
        wait_resp(2, 40, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_timeout2: no second instr_mem_resp within 40 cycles");
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            n_vec++;
            if (obs_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL b2b_cmd: no command, required wr=%b addr=%h", e.wr, e.addr);
            end else begin
                o = obs_cmd_q.pop_front();
                if (o.wr !== e.wr || o.addr !== e.addr) begin
                    n_err++;
                    $display("FAIL b2b_cmd: got wr=%b addr=%h, required wr=%b addr=%h", o.wr, o.addr, e.wr, e.addr);
                end
            end
        end
        n_vec++;
        if (obs_cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_extra_cmd: %0d extra commands, required 0", obs_cmd_q.size());
        end
        obs_cmd_q.delete();
        while (exp_resp_q.size() > 0) begin
            re = exp_resp_q.pop_front();
            n_vec++;
            if (obs_resp_q.size() == 0) begin
                n_err++;
                $display("FAIL b2b_resp: no response, required i=%b d=%b", re.i, re.d);
            end else begin
                ro = obs_resp_q.pop_front();
                if (ro.i !== re.i || ro.d !== re.d || ro.irdata !== re.irdata ||
                    ro.drdata !== re.drdata || ro.cyc != re.cyc) begin
                    n_err++;
                    $display("FAIL b2b_resp: got i=%b d=%b ird=%h drd=%h cyc=%0d, required i=%b d=%b ird=%h drd=%h cyc=%0d",
                             ro.i, ro.d, ro.irdata, ro.drdata, ro.cyc, re.i, re.d, re.irdata, re.drdata, re.cyc);
                end
            end
        end
        n_vec++;
        if (obs_resp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_extra_resp: %0d extra responses, required 0", obs_resp_q.size());
        end
        obs_resp_q.delete();
        $display("back_to_back: fetched 00000000 then 00000004");
    endtask

    task automatic test_spurious();
        @(negedge clk);
        spurious = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (obs_resp_q.size() != 0) begin
            n_err++;
            $display("FAIL spurious_resp: %0d CPU responses, required 0", obs_resp_q.size());
        end
        obs_resp_q.delete();
        n_vec++;
        if (bus.instr_mem_rdata !== exp_ibuf || bus.data_mem_rdata !== exp_dbuf) begin
            n_err++;
            $display("FAIL spurious_bufs: instr=%h data=%h, required instr=%h data=%h",
                     bus.instr_mem_rdata, bus.data_mem_rdata, exp_ibuf, exp_dbuf);
        end
        n_vec++;
        if (obs_cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL spurious_cmd: %0d pmem commands, required 0", obs_cmd_q.size());
        end
        obs_cmd_q.delete();
        $display("spurious: pmem_resp pulse in IDLE");
    endtask

    task automatic test_reset_mid();
        cmd_t e, o;
        resp_enable_off();
        push_cmd(1'b0, 32'h3000, 32'h0, 4'h0);
        bus.data_read        = 1'b1;
        bus.data_mem_address = 32'h3000;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h3000) begin
            n_err++;
            $display("FAIL abort_cmd_on: read=%b addr=%h, required read=1 addr=00003000",
                     bus.pmem_read, bus.pmem_address);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL abort_cmd_off: read=%b write=%b, required 0 0", bus.pmem_read, bus.pmem_write);
        end
        exp_ibuf = 32'h0;
        exp_dbuf = 32'h0;
        n_vec++;
        if (bus.instr_mem_rdata !== exp_ibuf || bus.data_mem_rdata !== exp_dbuf) begin
            n_err++;
            $display("FAIL abort_bufs: instr=%h data=%h, required 0", bus.instr_mem_rdata, bus.data_mem_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        resp_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (obs_resp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_no_resp: %0d CPU responses, required 0", obs_resp_q.size());
        end
        obs_resp_q.delete();
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            n_vec++;
            if (obs_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL abort_cmd: no command, required wr=%b addr=%h", e.wr, e.addr);
            end else begin
                o = obs_cmd_q.pop_front();
                if (o.wr !== e.wr || o.addr !== e.addr) begin
                    n_err++;
                    $display("FAIL abort_cmd: got wr=%b addr=%h, required wr=%b addr=%h", o.wr, o.addr, e.wr, e.addr);
                end
            end
        end
        n_vec++;
        if (obs_cmd_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_extra_cmd: %0d extra commands, required 0", obs_cmd_q.size());
        end
        obs_cmd_q.delete();
        $display("reset_mid: load 00003000 aborted");
    endtask

    task automatic resp_enable_off();
        resp_en = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_fetch_only();
        test_fetch_and_load();
        test_store();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_fetch_and_load();      // arbiter usable again after the abort
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low; asserted when rst=0 at a rising clk edge.
REQ-003 instr_read  input  1  CPU instruction fetch request; level, held until instr_mem_resp.
REQ-004 instr_mem_address  input  32  fetch byte address.
REQ-005 instr_mem_rdata  output  32  fetched word.
REQ-006 instr_mem_resp  output  1  fetch complete, one-cycle pulse.
REQ-007 data_read / data_write  input  1 each  CPU data request; level, held until data_mem_resp.
REQ-008 data_mem_address  input  32  data byte address; bits [1:0] ignored.
REQ-009 data_mem_wdata  input  32  write data, already lane-shifted.
REQ-010 data_mbe  input  4  byte enables for writes.
REQ-011 data_mem_rdata  output  32  loaded word.
REQ-012 data_mem_resp  output  1  data access complete, one-cycle pulse.
REQ-013 pmem_read / pmem_write  output  1 each  single-port memory command; level, held until pmem_resp.
REQ-014 pmem_address  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 pmem_wdata  output  32 / pmem_mbe  output  4  write data and byte enables.
REQ-016 pmem_rdata  input  32 / pmem_resp  input  1  memory read data; completion pulse, one or more cycles after the command.

Function
REQ-017 FSM states: IDLE, DATA, INSTR, RELEASE.
REQ-018 IDLE: sample requests; set i_pend=instr_read and d_pend=data_read|data_write; latch both addresses, wdata, mbe, and the write flag (data_write wins if read and write are both high).
REQ-019 IDLE -> DATA if d_pend; else -> INSTR if i_pend; else stay IDLE.
REQ-020 DATA: drive pmem_read=~wr or pmem_write=wr from latched values.
  - On pmem_resp, capture pmem_rdata into the data buffer (reads only; writes leave the buffer unchanged).
  - Then go to INSTR if i_pend, else RELEASE.
REQ-021 INSTR: drive pmem_read with the latched fetch address; on pmem_resp, capture into the instr buffer and go to RELEASE.
REQ-022 Data is served before instruction whenever both are pending.
REQ-023 RELEASE: for exactly one cycle, instr_mem_resp=i_pend and data_mem_resp=d_pend, asserted together; then -> IDLE.
  - This guarantees the stalled pipeline sees every pending response in the same cycle and never re-issues a completed request.
REQ-024 pmem_read and pmem_write are never asserted together, and are 0 in IDLE and RELEASE.
REQ-025 pmem_* outputs are stable for the whole DATA or INSTR state, independent of CPU inputs after the IDLE latch.
REQ-026 instr_mem_rdata and data_mem_rdata are registered buffers; they are valid in RELEASE and hold their value otherwise.
REQ-027 Minimum latency with pmem_resp in the first command cycle:
  - single port: request sampled in cycle 0, command in cycle 1, resp in cycle 2;
  - both ports: resps in cycle 3.
REQ-028 Requests that change or deassert outside IDLE are ignored.
REQ-029 A request held high into IDLE immediately after RELEASE is treated as a new request.
REQ-030 pmem_resp arriving in IDLE or RELEASE is ignored.

Reset
REQ-031 While rst=0, at the clock edge: state=IDLE, i_pend=d_pend=0, all buffers and latches 0.
REQ-032 While in reset, all outputs are 0.
REQ-033 Reset during DATA or INSTR aborts the access: pmem commands drop in the next cycle and no CPU resp is issued for the aborted request.

Verification
REQ-034 Fetch only:
  - stimulus: instr_read=1, addr 0x60, pmem responds 0x00000013 after 2 cycles;
  - required: pmem_read with pmem_address=0x60, then instr_mem_resp pulse with instr_mem_rdata=0x00000013, data_mem_resp=0.
REQ-035 Simultaneous fetch and load:
  - stimulus: fetch 0x64 and load 0x1002;
  - required: first command is pmem_read at 0x1000, second at 0x64, then both resps high in the same single cycle with correct buffered data.
REQ-036 Store:
  - stimulus: data_write=1, addr 0x2003, mbe=4'b1000, wdata=0xAB000000;
  - required: pmem_write with pmem_address=0x2000, pmem_mbe=4'b1000, pmem_wdata=0xAB000000, then data_mem_resp; data_mem_rdata unchanged.
REQ-037 Back-to-back fetches:
  - stimulus: instr_read held high, address changes 0x0 -> 0x4 on the cycle after resp;
  - required: two distinct pmem reads, no duplicate fetch of 0x0.
REQ-038 Reset mid-access:
  - stimulus: rst=0 while in DATA with pmem_resp not yet seen;
  - required: next cycle pmem_read=0, no data_mem_resp, FSM back in IDLE.
REQ-039 Spurious pmem_resp:
  - stimulus: pmem_resp pulse while in IDLE;
  - required: no CPU resp and buffers unchanged.
